bw_dot_accum: RTL
=================

Name: bw_dot_accum

Overview:
- Downstream consumer of the registered 8x6 signed Baugh-Wooley multiplier.
- Accumulates a programmed-length stream of 14-bit two's-complement products into a saturating signed dot-product result.
- Presents the result through a valid/ready handshake.
- Frames jobs with a start/len command, so a multiplier plus this block forms a fixed-point MAC.

Parameters:
- PROD_W, 14, width of signed product input.
- ACC_W, 20, width of signed accumulator and result.
- LEN_W, 8, width of job length field (max 255 products).

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  synchronous reset, active-high.
- start  input  1  job request; sampled only when accepted (see Behaviour).
- len  input  LEN_W  number of products in job; sampled with accepted start.
- prod_in  input  PROD_W  signed product from multiplier output register.
- prod_valid  input  1  prod_in carries a product this cycle.
- busy  output  1  high in ACC state.
- acc_out  output  ACC_W  signed result; stable while out_valid=1.
- out_valid  output  1  result available.
- out_ready  input  1  consumer accepts result.
- sat  output  1  sticky per job: one or more additions saturated.

Behaviour:
- Reset is clk, rst: synchronous, active-high. rst=1 at any edge, in any state, forces:
  - state=IDLE, acc_out=0, out_valid=0, busy=0, sat=0, count=0.
  - Any job in progress is discarded.
- All outputs are registered.
- States: IDLE, ACC, DONE.
- IDLE:
  - start=1, len!=0: acc<=0, sat<=0, count<=len, go ACC.
  - start=1, len==0: acc<=0, sat<=0, go DONE (empty job; result 0 next cycle).
  - prod_valid ignored.
- ACC (busy=1):
  - prod_valid=1: acc<=satadd(acc, sext(prod_in)), count<=count-1.
  - If count==1 on that cycle, go DONE.
  - prod_valid=0: hold acc and count; no timeout.
  - start ignored.
- DONE (out_valid=1, acc_out=final acc, busy=0):
  - out_ready=0: hold acc_out, sat and out_valid unchanged.
  - out_ready=1, start=0: go IDLE; out_valid low next cycle.
  - out_ready=1, start=1: completes handshake and accepts the new job in the same cycle. Next state follows the IDLE rules with that len. No bubble.
  - prod_valid ignored (dropped) in DONE.
- Latency: out_valid rises on the cycle after the edge that accepts the last product.
- Arithmetic:
  - prod_in is sign-extended to ACC_W+1 bits and summed with acc.
  - Sum > 2^(ACC_W-1)-1: acc<=2^(ACC_W-1)-1, sat<=1.
  - Sum < -2^(ACC_W-1): acc<=-2^(ACC_W-1), sat<=1.
  - Saturation clamps each step; later additions continue from the clamped value.
- sat clears only on accepted start or rst. It remains valid with the result through DONE.
- Product range from the 8x6 multiplier is [-4064, 4096]. Saturation is reachable for len >= 128 at ACC_W=20.
- acc_out retains the last result in IDLE until the next accepted start clears it.

Test Plan:
- Reset: drive rst=1 two cycles with random inputs -> acc_out=0, out_valid=0, busy=0, sat=0. start ignored while rst=1.
- Basic job: start, len=3; products 100, -50, 4096 on consecutive cycles -> out_valid rises one cycle after 4096 is accepted. acc_out=4146, sat=0, busy low in DONE.
- Gaps and backpressure:
  - len=4, products 7, -3, -4064, 1 with prod_valid low 1-3 cycles between them -> acc_out=-4059.
  - Hold out_ready=0 for 5 cycles while toggling prod_valid -> acc_out and out_valid stable, extra products not summed.
- Saturation:
  - len=200, all 4096 -> acc_out=524287, sat=1.
  - Next job len=200, all -4064 -> acc_out=-524288, sat=1.
  - Next job len=1, product 5 -> acc_out=5, sat=0.
- Edge lengths:
  - len=0 start -> out_valid next cycle, acc_out=0, no products consumed.
  - len=255, all -1 -> acc_out=-255.
- Back-to-back and mid-job reset:
  - In DONE, assert out_ready=1 and start=1 with len=2 -> next cycle busy=1, out_valid=0. Products 10, 20 -> acc_out=30.
  - rst during ACC after 2 of 5 products -> IDLE, all outputs 0. A following job (len=1, product 9) returns 9.

Source files
------------

// File: rtl/bw_dot_accum_if.sv
// Handshake bundle between the multiplier/job controller and bw_dot_accum.
// slave is the accumulator side; master drives jobs and products and consumes results.
interface bw_dot_accum_if #(
  parameter int PROD_W = 14,
  parameter int ACC_W  = 20,
  parameter int LEN_W  = 8
);
  logic              start;
  logic [LEN_W-1:0]  len;
  logic [PROD_W-1:0] prod_in;
  logic              prod_valid;
  logic              busy;
  logic [ACC_W-1:0]  acc_out;
  logic              out_valid;
  logic              out_ready;
  logic              sat;

  modport slave (
    input  start, len, prod_in, prod_valid, out_ready,
    output busy, acc_out, out_valid, sat
  );

  modport master (
    output start, len, prod_in, prod_valid, out_ready,
    input  busy, acc_out, out_valid, sat
  );
endinterface

// File: rtl/bw_dot_accum.sv
// Saturating signed dot-product accumulator fed by the 8x6 Baugh-Wooley multiplier.
// Jobs are framed by start/len; the result leaves through a valid/ready handshake.
module bw_dot_accum #(
  parameter int PROD_W = 14,
  parameter int ACC_W  = 20,
  parameter int LEN_W  = 8
) (
  input  logic          clk,
  input  logic          rst,
  bw_dot_accum_if.slave bus
);
  // state | meaning
  // IDLE  | waiting for start; acc_out keeps the previous result
  // ACC   | summing products until count reaches zero
  // DONE  | result presented with out_valid until out_ready
  typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;

  localparam int EXT_W = ACC_W + 1 - PROD_W;
  localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  state_t            state_q, state_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [LEN_W-1:0]  count_q, count_d;
  logic              sat_q, sat_d;
  logic              busy_q, busy_d;
  logic              out_valid_q, out_valid_d;

  logic [ACC_W:0]    sum;
  logic [ACC_W-1:0]  sum_clamped;
  logic              sum_ovf;

  // One guard bit above the accumulator exposes overflow as a sign-bit disagreement.
  always_comb begin
    sum = {acc_q[ACC_W-1], acc_q}
        + {{EXT_W{bus.prod_in[PROD_W-1]}}, bus.prod_in};
    sum_ovf = sum[ACC_W] ^ sum[ACC_W-1];
    if (!sum_ovf)
      sum_clamped = sum[ACC_W-1:0];
    else if (sum[ACC_W])
      sum_clamped = ACC_MIN;
    else
      sum_clamped = ACC_MAX;
  end

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    count_d     = count_q;
    sat_d       = sat_q;
    busy_d      = busy_q;
    out_valid_d = out_valid_q;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          acc_d = '0;
          sat_d = 1'b0;
          if (bus.len != '0) begin
            count_d = bus.len;
            state_d = ACC;
            busy_d  = 1'b1;
          end else begin
            count_d     = '0;
            state_d     = DONE;
            out_valid_d = 1'b1;
          end
        end
      end

      ACC: begin
        if (bus.prod_valid) begin
          acc_d   = sum_clamped;
          sat_d   = sat_q | sum_ovf;
          count_d = count_q - LEN_W'(1);
          if (count_q == LEN_W'(1)) begin
            state_d     = DONE;
            busy_d      = 1'b0;
            out_valid_d = 1'b1;
          end
        end
      end

      DONE: begin
        if (bus.out_ready) begin
          // A start in the handshake cycle is taken immediately, with no idle bubble.
          if (bus.start) begin
            acc_d = '0;
            sat_d = 1'b0;
            if (bus.len != '0) begin
              count_d     = bus.len;
              state_d     = ACC;
              busy_d      = 1'b1;
              out_valid_d = 1'b0;
            end else begin
              count_d     = '0;
              state_d     = DONE;
              out_valid_d = 1'b1;
            end
          end else begin
            state_d     = IDLE;
            out_valid_d = 1'b0;
          end
        end
      end

      default: begin
        state_d     = IDLE;
        busy_d      = 1'b0;
        out_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      count_q     <= '0;
      sat_q       <= 1'b0;
      busy_q      <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      count_q     <= count_d;
      sat_q       <= sat_d;
      busy_q      <= busy_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.busy      = busy_q;
  assign bus.acc_out   = acc_q;
  assign bus.out_valid = out_valid_q;
  assign bus.sat       = sat_q;
endmodule
